// File: rtl/test_checker.sv
// test_checker: end-of-test result checker for a CPU testbench harness.
//
// A run starts on `start`. The checker waits up to RUN_CYCLES cycles, or
// until `cpu_halt`. It then scans the register file and a set of memory
// slots against programmed expectation tables, and reports pass/fail.
//
// Configuration macro: CHECKER_EARLY_EXIT_EN
//   defined   - the first mismatch ends the scan; DONE follows on the next edge
//   undefined - every entry is scanned and fail_count is complete
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   start             one-cycle pulse, accepted in IDLE/DONE only
//   cpu_halt          ends RUN early
//   exp_we/sel/idx    expectation table write (sel 0 = reg, 1 = mem)
//   exp_addr/data/mask  table entry contents (all-zero mask disables the entry)
//   reg_raddr/rdata   register-file read port (combinational data)
//   mem_raddr/rdata   data-memory read port (data one cycle after address)
//   busy, done, pass  status
//   fail_count        mismatch count, saturating at 255
//   first_fail_id/val {is_mem, index} and observed value of the first mismatch
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | after reset; tables writable, waiting for start
// RUN     | CPU runs; counts cycles until RUN_CYCLES-1 or cpu_halt
// CHK_REG | one register entry compared per cycle, 0..NUM_REGS-1
// CHK_MEM | pipelined memory compare: address in cycle k, compare in k+1
// DONE    | result held; tables writable; start begins a new run

module test_checker #(
  parameter int NUM_REGS   = 32,
  parameter int MEM_CHECKS = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int RUN_CYCLES = 10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpu_halt,
  input  logic              exp_we,
  input  logic              exp_sel,
  input  logic [5:0]        exp_idx,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [DATA_W-1:0] exp_mask,
  output logic [4:0]        reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        fail_count,
  output logic [6:0]        first_fail_id,
  output logic [DATA_W-1:0] first_fail_val
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    CHK_REG = 3'd2,
    CHK_MEM = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam int RI_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int MI_W  = (MEM_CHECKS > 1) ? $clog2(MEM_CHECKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYCLES - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [6:0]        idx;       // scan index; reaches MEM_CHECKS in CHK_MEM
  logic [6:0]        idx_prev;  // memory slot being compared this cycle
  logic [RI_W-1:0]   ri;
  logic [MI_W-1:0]   mi, mp;

  logic [DATA_W-1:0] reg_exp  [NUM_REGS];
  logic [DATA_W-1:0] reg_mask [NUM_REGS];
  logic [ADDR_W-1:0] mem_addr_t [MEM_CHECKS];
  logic [DATA_W-1:0] mem_exp  [MEM_CHECKS];
  logic [DATA_W-1:0] mem_mask [MEM_CHECKS];

  logic              mismatch;
  logic [DATA_W-1:0] obs_val;
  logic [6:0]        obs_id;
  logic              start_ok;
  logic              wr_ok;

  assign idx_prev = idx - 7'd1;
  assign ri       = idx[RI_W-1:0];
  assign mi       = idx[MI_W-1:0];
  assign mp       = idx_prev[MI_W-1:0];

  assign busy     = (state == RUN) || (state == CHK_REG) || (state == CHK_MEM);
  assign done     = (state == DONE);
  assign pass     = done && (fail_count == 8'd0);
  assign start_ok = start && !busy;
  assign wr_ok    = exp_we && !busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    mismatch  = 1'b0;
    obs_val   = '0;
    obs_id    = '0;
    reg_raddr = '0;
    mem_raddr = '0;
    case (state)
      IDLE, DONE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        if (cpu_halt || (cnt == CNT_LAST)) state_n = CHK_REG;
      end
      CHK_REG: begin
        reg_raddr = idx[4:0];
        obs_val   = reg_rdata;
        obs_id    = {1'b0, idx[5:0]};
        mismatch  = (((reg_rdata ^ reg_exp[ri]) & reg_mask[ri]) != '0);
        if (idx == 7'(NUM_REGS - 1)) state_n = CHK_MEM;
      end
      CHK_MEM: begin
        if (idx < 7'(MEM_CHECKS)) mem_raddr = mem_addr_t[mi];
        // Cycle 0 only issues an address; data for slot k-1 arrives in cycle k.
        if (idx != 7'd0) begin
          obs_val  = mem_rdata;
          obs_id   = {1'b1, idx_prev[5:0]};
          mismatch = (((mem_rdata ^ mem_exp[mp]) & mem_mask[mp]) != '0);
        end
        if (idx == 7'(MEM_CHECKS)) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
`ifdef CHECKER_EARLY_EXIT_EN
    if (mismatch) state_n = DONE;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (start_ok) begin
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
      end
      if (state_n != state) begin
        idx <= '0;
      end else if ((state == CHK_REG) || (state == CHK_MEM)) begin
        idx <= idx + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_count     <= '0;
      first_fail_id  <= '0;
      first_fail_val <= '0;
    end else if (start_ok) begin
      fail_count     <= '0;
      first_fail_id  <= '0;
      first_fail_val <= '0;
    end else if (mismatch) begin
      if (fail_count == 8'd0) begin
        first_fail_id  <= obs_id;
        first_fail_val <= obs_val;
      end
      if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
    end
  end

  // Expectation tables. Out-of-range indices are dropped rather than wrapped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_exp[i]  <= '0;
        reg_mask[i] <= '0;
      end
      for (int i = 0; i < MEM_CHECKS; i++) begin
        mem_addr_t[i] <= '0;
        mem_exp[i]    <= '0;
        mem_mask[i]   <= '0;
      end
    end else if (wr_ok) begin
      if (!exp_sel && ({26'd0, exp_idx} < 32'(NUM_REGS))) begin
        reg_exp[exp_idx[RI_W-1:0]]  <= exp_data;
        reg_mask[exp_idx[RI_W-1:0]] <= exp_mask;
      end else if (exp_sel && ({26'd0, exp_idx} < 32'(MEM_CHECKS))) begin
        mem_addr_t[exp_idx[MI_W-1:0]] <= exp_addr;
        mem_exp[exp_idx[MI_W-1:0]]    <= exp_data;
        mem_mask[exp_idx[MI_W-1:0]]   <= exp_mask;
      end
    end
  end

endmodule

// File: tb/tb_test_checker.sv
module tb_test_checker;
  localparam int NR = 32;
  localparam int MC = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RC = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, cpu_halt, exp_we, exp_sel;
  logic [5:0]    exp_idx;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data, exp_mask;
  logic [4:0]    reg_raddr;
  logic [DW-1:0] reg_rdata;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          busy, done, pass;
  logic [7:0]    fail_count;
  logic [6:0]    first_fail_id;
  logic [DW-1:0] first_fail_val;

  test_checker #(.NUM_REGS(NR), .MEM_CHECKS(MC), .DATA_W(DW), .ADDR_W(AW),
                 .RUN_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .start(start), .cpu_halt(cpu_halt),
    .exp_we(exp_we), .exp_sel(exp_sel), .exp_idx(exp_idx),
    .exp_addr(exp_addr), .exp_data(exp_data), .exp_mask(exp_mask),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .first_fail_id(first_fail_id), .first_fail_val(first_fail_val));

  always #5 clk = ~clk;

  // CPU-side register file and memory.
  logic [DW-1:0] regs [NR];
  logic [DW-1:0] tmem [1024];
  assign reg_rdata = regs[reg_raddr];
  always_ff @(posedge clk) mem_rdata <= tmem[mem_raddr[11:2]];

  // Reference copy of the expectation tables.
  logic [DW-1:0] m_rexp [NR];
  logic [DW-1:0] m_rmask[NR];
  logic [AW-1:0] m_maddr[MC];
  logic [DW-1:0] m_mexp [MC];
  logic [DW-1:0] m_mmask[MC];

  int checks = 0;
  int errors = 0;
  int obs_n, obs_fc, obs_fid;
  logic [DW-1:0] obs_fv;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin m_rexp[i] = '0; m_rmask[i] = '0; end
    for (int i = 0; i < MC; i++) begin m_maddr[i] = '0; m_mexp[i] = '0; m_mmask[i] = '0; end
  endtask

  task automatic model_wr(input logic sel, input logic [5:0] idx, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] m);
    if (!sel && int'(idx) < NR) begin
      m_rexp[idx] = d; m_rmask[idx] = m;
    end else if (sel && int'(idx) < MC) begin
      m_maddr[idx] = a; m_mexp[idx] = d; m_mmask[idx] = m;
    end
  endtask

  task automatic drive_wr(input logic sel, input logic [5:0] idx, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] m);
    exp_we = 1'b1; exp_sel = sel; exp_idx = idx; exp_addr = a; exp_data = d; exp_mask = m;
  endtask

  task automatic wr(input logic sel, input logic [5:0] idx, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input logic [DW-1:0] m);
    drive_wr(sel, idx, a, d, m);
    tick();
    exp_we = 1'b0;
    model_wr(sel, idx, a, d, m);
  endtask

  // Expected outcome: list every failing entry in scan order, then derive
  // count, first failure and the number of edges from start to DONE.
  task automatic model(input int run_len, output int lat, output int fc,
                       output int fid, output logic [DW-1:0] fv);
    int n = 0;
    int first_pos = 0;
    logic [DW-1:0] v;
    fid = 0; fv = '0;
    for (int r = 0; r < NR; r++) begin
      if (((regs[r] ^ m_rexp[r]) & m_rmask[r]) != 0) begin
        if (n == 0) begin fid = r; fv = regs[r]; first_pos = r; end
        n++;
      end
    end
    for (int k = 0; k < MC; k++) begin
      v = tmem[m_maddr[k][11:2]];
      if (((v ^ m_mexp[k]) & m_mmask[k]) != 0) begin
        if (n == 0) begin fid = 64 + k; fv = v; first_pos = NR + k + 1; end
        n++;
      end
    end
`ifdef CHECKER_EARLY_EXIT_EN
    fc  = (n > 0) ? 1 : 0;
    lat = (n > 0) ? run_len + first_pos + 1 : run_len + NR + MC + 1;
`else
    fc  = (n > 255) ? 255 : n;
    lat = run_len + NR + MC + 1;
`endif
  endtask

  task automatic run(input string tag, input int halt, input bit do_wr, input logic [5:0] widx,
                     input logic [DW-1:0] wdata);
    int rl, lat, fc, fid, n;
    logic [DW-1:0] fv;
    bit seen;
    start = 1'b1;
    if (do_wr) drive_wr(1'b0, widx, '0, wdata, '1);
    tick();
    start = 1'b0; exp_we = 1'b0;
    if (do_wr) model_wr(1'b0, widx, '0, wdata, '1);
    rl = (halt > 0 && halt < RC) ? halt : RC;
    model(rl, lat, fc, fid, fv);
    chk({tag, "_busy"}, busy, 1);
    n = 0; seen = 0;
    while (n < 300 && !seen) begin
      cpu_halt = (halt > 0 && n + 1 == halt);
      if (n == 2) drive_wr(1'b0, 6'd0, '0, ~regs[0], '1);  // must be ignored while busy
      tick();
      n++;
      exp_we = 1'b0; cpu_halt = 1'b0;
      if (halt > 0 && n == rl && lat > rl + 1) chk({tag, "_halt_raddr0"}, reg_raddr, 0);
      if (halt > 0 && n == rl + 1 && lat > rl + 1) chk({tag, "_halt_raddr1"}, reg_raddr, 1);
      if (done) seen = 1;
    end
    obs_n = n; obs_fc = fail_count; obs_fid = first_fail_id; obs_fv = first_fail_val;
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_pass"}, pass, (fc == 0));
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_fail_count"}, fail_count, fc);
    if (fc > 0) begin
      chk({tag, "_first_id"}, first_fail_id, fid);
      chk({tag, "_first_val"}, first_fail_val, fv);
    end
    chk({tag, "_raddr_idle"}, {reg_raddr, mem_raddr}, 0);
  endtask

  initial begin
    int exp_fc;
    start = 0; cpu_halt = 0; exp_we = 0; exp_sel = 0; exp_idx = 0;
    exp_addr = 0; exp_data = 0; exp_mask = 0;
    for (int i = 0; i < NR; i++) regs[i] = '0;
    for (int i = 0; i < 1024; i++) tmem[i] = '0;
    model_clear();
    rst = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fc", fail_count, 0);
    chk("rst_first", {first_fail_id, first_fail_val}, 0);
    chk("rst_raddr", {reg_raddr, mem_raddr}, 0);
    tick(); rst = 1'b1; tick();

    // Register x1 matches; nominal latency 8 + 32 + 5.
    regs[1] = 32'h0A;
    wr(0, 6'd1, '0, 32'h0A, '1);
    run("x1_ok", 0, 0, 0, 0);
    chk("x1_ok_const_lat", obs_n, 45);

    // Memory slot 1 mismatches.
    tmem[(32'h1000 >> 2) & 1023] = 32'h0A;
    tmem[(32'h1004 >> 2) & 1023] = 32'h15;
    wr(1, 6'd0, 32'h1000, 32'h0A, '1);
    wr(1, 6'd1, 32'h1004, 32'h14, '1);
    run("mem_fail", 0, 0, 0, 0);
    chk("mem_fail_const", {obs_fc[7:0], obs_fid[6:0], obs_fv}, {8'd1, 7'h41, 32'h15});

    // cpu_halt on the 3rd RUN cycle.
    wr(1, 6'd1, 32'h1004, 32'h15, '1);
    run("halt3", 3, 0, 0, 0);
    chk("halt3_const_lat", obs_n, 3 + 37);

    // Partial mask ignores the upper bits of x5.
    regs[5] = 32'h12345000;
    wr(0, 6'd5, '0, 32'h0, 32'hFF);
    run("mask_x5", 0, 0, 0, 0);
    chk("mask_x5_pass", pass, 1);

    // Out-of-range indices must not wrap onto x0 or slot 0.
    wr(0, 6'd32, '0, 32'hDEAD, '1);
    wr(1, 6'd4, 32'h0, 32'hBEEF, '1);
    run("oob", 0, 0, 0, 0);

    // Two register mismatches, x2 and x3.
    regs[2] = 32'h1111; regs[3] = 32'h2222;
    wr(0, 6'd2, '0, 32'h1112, '1);
    wr(0, 6'd3, '0, 32'h2223, '1);
    run("x2x3", 0, 0, 0, 0);
`ifdef CHECKER_EARLY_EXIT_EN
    exp_fc = 1;
    chk("x2x3_const_lat", obs_n, RC + 3);
`else
    exp_fc = 2;
`endif
    chk("x2x3_const", {obs_fc[7:0], obs_fid[6:0]}, {exp_fc[7:0], 7'h02});

    // Reset in the middle of CHK_REG, with failing entries still programmed.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < RC + 4; i++) tick();
    rst = 1'b0; #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_fc", fail_count, 0);
    chk("midrst_raddr", reg_raddr, 0);
    model_clear();
    tick(); rst = 1'b1; tick();
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    run("post_rst", 0, 0, 0, 0);
    chk("post_rst_pass", pass, 1);

    // Randomized tables, CPU state and halt points.
    for (int it = 0; it < 6; it++) begin
      logic [DW-1:0] m;
      logic [AW-1:0] a;
      int h;
      for (int r = 0; r < NR; r++) regs[r] = $urandom;
      for (int r = 0; r < NR; r++) begin
        case ($urandom_range(0, 3))
          0: m = '0;
          1: m = '1;
          default: m = $urandom;
        endcase
        wr(0, 6'(r), '0, ($urandom_range(0, 7) == 0) ? $urandom : regs[r], m);
      end
      for (int k = 0; k < MC; k++) begin
        a = 32'h1000 + 4 * $urandom_range(0, 255);
        tmem[a[11:2]] = $urandom;
        wr(1, 6'(k), a, ($urandom_range(0, 3) == 0) ? $urandom : tmem[a[11:2]], '1);
      end
      wr(0, 6'(32 + $urandom_range(0, 31)), '0, $urandom, '1);
      wr(1, 6'(MC + $urandom_range(0, 59)), $urandom, $urandom, '1);
      h = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0;
      if (it % 2 == 0) run($sformatf("rnd%0d", it), h, 1, 6'($urandom_range(0, NR - 1)), $urandom);
      else run($sformatf("rnd%0d", it), h, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/test_checker.md
TEST_CHECKER -- requirements
Module: test_checker

Interface
REQ-001 Parameter NUM_REGS, 32, register-file entries scanned; x0 is included.
REQ-002 Parameter MEM_CHECKS, 4, number of memory-check slots (1..64).
REQ-003 Parameter DATA_W, 32, width of register/memory data and expected values.
REQ-004 Parameter ADDR_W, 32, memory address width.
REQ-005 Parameter RUN_CYCLES, 10000, maximum cycles in RUN before checking begins (>=1).
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
REQ-009 cpu_halt  in  1  DUT finished early; ends RUN on the next edge.
REQ-010 exp_we  in  1  write strobe for the expectation tables.
REQ-011 exp_sel  in  1  0 = register table, 1 = memory table.
REQ-012 exp_idx  in  6  table index.
REQ-013 exp_addr  in  ADDR_W  memory address; memory table only.
REQ-014 exp_data  in  DATA_W  expected value.
REQ-015 exp_mask  in  DATA_W  compare mask; a bit set to 1 is compared; an all-zero mask disables the entry.
REQ-016 reg_raddr  out  5  register-file read index.
REQ-017 reg_rdata  in  DATA_W  combinational register read data, valid in the same cycle.
REQ-018 mem_raddr  out  ADDR_W  data-memory read address.
REQ-019 mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_raddr.
REQ-020 busy, done, pass  out  1 each  status outputs.
REQ-021 fail_count  out  8  number of mismatches, saturating at 255.
REQ-022 first_fail_id  out  7  bit 6 = memory; bits 5:0 = index of the first mismatch.
REQ-023 first_fail_val  out  DATA_W  observed value at the first mismatch.

Function
REQ-024 The FSM states SHALL be IDLE, RUN, CHK_REG, CHK_MEM and DONE.
REQ-025 IDLE/DONE + start: go to RUN; clear the cycle counter, fail_count, first_fail_* and done.
REQ-026 RUN: increment the counter each cycle; go to CHK_REG when the counter reaches RUN_CYCLES-1 or cpu_halt=1, whichever comes first.
REQ-027 CHK_REG: scan one entry per cycle, indices 0..NUM_REGS-1.
  - reg_raddr = index.
  - Compare (reg_rdata ^ exp) & mask in the same cycle.
  - A disabled entry still takes one cycle.
  - Total NUM_REGS cycles.
REQ-028 CHK_MEM: pipelined; issue mem_raddr for slot k in cycle k and compare in cycle k+1.
  - Total MEM_CHECKS+1 cycles.
  - Then go to DONE.
REQ-029 On a mismatch, fail_count increments (saturating at 255); first_fail_id and first_fail_val are captured only when fail_count was 0.
REQ-030 DONE: done=1 and pass=(fail_count==0), both held until the next start or reset.
REQ-031 busy=1 in RUN, CHK_REG and CHK_MEM.
REQ-032 start while busy is ignored.
REQ-033 exp_we while busy is ignored; exp_we in IDLE or DONE writes the table entry at the next edge.
REQ-034 exp_idx beyond the table size is ignored; no wrap-around.
REQ-035 start and exp_we in the same cycle: the write is committed first, and the run uses the new value.
REQ-036 reg_raddr and mem_raddr SHALL be 0 outside CHK_REG and CHK_MEM.

Reset
REQ-037 Asserting rst SHALL immediately force:
  - the FSM to IDLE;
  - the counter, fail_count, first_fail_*, busy, done, pass and the address outputs to 0;
  - all mask entries to 0, which disables them.
REQ-038 Reset during any state aborts the run; nothing is reported and done stays 0.

Configuration
REQ-039 Macro CHECKER_EARLY_EXIT_EN.
  - Defined: the first mismatch goes to DONE on the next edge with pass=0, and the remaining entries are skipped.
  - Undefined: every entry is always scanned, so fail_count is complete.

Verification
REQ-040 Write reg x1 exp=0x0000000A with full mask, hold reg_rdata=0x0A, pulse start with RUN_CYCLES=8.
  - Required: done after 8+32+5 cycles, pass=1, fail_count=0.
REQ-041 Memory slot 0 = addr 0x00001000, exp 0x0A; slot 1 = addr 0x00001004, exp 0x14; memory returns 0x0A then 0x15.
  - Required: pass=0, fail_count=1, first_fail_id=0x41, first_fail_val=0x15.
REQ-042 cpu_halt asserted on the 3rd RUN cycle.
  - Required: CHK_REG is entered on the next edge, and reg_raddr=0 on that cycle.
REQ-043 Mask 0x000000FF on x5, exp 0x00, reg_rdata=0x12345000.
  - Required: that entry passes.
REQ-044 Assert rst mid CHK_REG.
  - Required: busy=0, done=0 and all masks cleared; a new start with empty tables then gives pass=1.
REQ-045 With CHECKER_EARLY_EXIT_EN defined, mismatches on x2 and x3.
  - Required: fail_count=1, first_fail_id=0x02, and DONE on the cycle after the x2 compare.
